temporizador_programable: RTL and testbench
===========================================

// Module: temporizador_programable
// PURPOSE
//  Countdown timer for the microwave controller. Selects a cook time from a
//  one-hot program selector: N_PRESETS fixed programs plus one manual time.
//  Counts that time down in seconds and handles start, pause, resume and
//  cancel. Signals completion to the display/alarm logic.
//  Sits between the front-panel decoder and the display/alarm driver.
// PARAMETERS
//  WIDTH      5                      bit width of times, T_selec and num
//  N_PRESETS  4                      number of fixed programs
//  PRESETS    {5'd20,5'd10,5'd5,5'd15}  packed preset times; field i = PRESETS[i*WIDTH +: WIDTH]
//                                    i=0 Pizza, 1 Mantequilla, 2 Palomitas, 3 Descongelar
//  TICK_DIV   50_000_000             clk cycles per 1-second tick (>=2)
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  seleccion  in   N_PRESETS+1        one-hot program select; bit N_PRESETS = manual; all-zero = standby
//  T_selec    in   WIDTH              manual time, in seconds
//  iniciar    in   1                  start/resume request, level sampled each clk
//  pausar     in   1                  pause request
//  cancelar   in   1                  cancel/acknowledge request
//  num        out  WIDTH              seconds remaining / selected time
//  activo     out  1                  1 while in CONTANDO
//  pausado    out  1                  1 while in PAUSA
//  fin        out  1                  1-cycle pulse on entry to FIN
//  alarma     out  1                  1 while in FIN
//  error_sel  out  1                  1 in STANDBY when seleccion is not one-hot and not zero
// BEHAVIOUR
//  - Reset (async): state=STANDBY; num=0; prescaler=0; all flags 0.
//  - Request priority within one cycle: cancelar > pausar > iniciar.
//  - STANDBY
//    - num is registered from seleccion, 1-cycle latency:
//      - one-hot bit i<N_PRESETS -> preset i
//      - manual bit -> T_selec
//      - zero -> 0
//      - multi-hot -> 0 and error_sel=1
//    - iniciar with a valid selection and nonzero value -> CONTANDO, prescaler=0.
//    - Otherwise iniciar is ignored.
//  - CONTANDO
//    - seleccion and T_selec are ignored.
//    - prescaler counts 0..TICK_DIV-1 and wraps.
//    - On the wrap cycle, num decrements by 1.
//    - When the decrement makes num 0 -> FIN. No underflow is possible.
//    - pausar -> PAUSA; prescaler and num hold. A tick due in the same cycle is suppressed.
//    - cancelar -> STANDBY; num reloads from seleccion on the next cycle.
//  - PAUSA
//    - iniciar -> CONTANDO; prescaler resumes from its held value.
//    - cancelar -> STANDBY.
//    - pausar has no effect.
//  - FIN
//    - fin=1 on the first FIN cycle only; alarma=1 throughout; num=0.
//    - cancelar or iniciar -> STANDBY. iniciar in FIN does NOT restart the timer.
//  - Outputs are registered. Flags change in the cycle after the causing input.
//  - All arithmetic is unsigned WIDTH bits. T_selec=0 in manual mode is treated as "not startable".
// TESTING (TICK_DIV=4 in bench)
//  1 rst pulse mid-count -> num=0, activo=0, state STANDBY immediately (async).
//  2 seleccion=5'b00010, iniciar 1 cycle -> num goes 5,4,..,0, one step every 4 clk;
//    fin pulses once; alarma stays 1 until cancelar.
//  3 manual T_selec=3, start, pausar after 5 clk for 20 clk, then iniciar ->
//    num frozen at 2 during the pause; total time to fin = 12 counting clk.
//  4 seleccion=5'b01100 -> error_sel=1, num=0; iniciar ignored, activo stays 0.
//  5 pausar+iniciar+cancelar asserted together in CONTANDO -> STANDBY;
//    num = current selection value next cycle.
//  6 change seleccion during CONTANDO -> countdown is unaffected;
//    T_selec=0 in manual mode + iniciar -> stays in STANDBY.

Source files
------------

// File: rtl/temporizador_programable.sv
// Programmable countdown timer for the microwave controller.
// One-hot program select, second prescaler, start/pause/resume/cancel FSM.
module temporizador_programable #(
  parameter int WIDTH = 5,
  parameter int N_PRESETS = 4,
  parameter logic [N_PRESETS*WIDTH-1:0] PRESETS =
    {5'd20, 5'd10, 5'd5, 5'd15},
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PRESETS:0]   seleccion,
  input  logic [WIDTH-1:0]     T_selec,
  input  logic                 iniciar,
  input  logic                 pausar,
  input  logic                 cancelar,
  output logic [WIDTH-1:0]     num,
  output logic                 activo,
  output logic                 pausado,
  output logic                 fin,
  output logic                 alarma,
  output logic                 error_sel
);

  localparam int NS = N_PRESETS + 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    STANDBY,
    CONTANDO,
    PAUSA,
    FIN
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] num_n;
  logic [WIDTH-1:0] sel_val;
  logic             sel_multi;
  logic             sel_ok;
  logic             tick;

  // Multi-hot selections decode to zero so they can never start.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_PRESETS; i++) begin
      if (seleccion[i])
        sel_val = sel_val | PRESETS[i*WIDTH +: WIDTH];
    end
    if (seleccion[N_PRESETS])
      sel_val = sel_val | T_selec;
    sel_multi = (seleccion & (seleccion - NS'(1))) != '0;
    if (sel_multi)
      sel_val = '0;
  end

  assign sel_ok = !sel_multi && (sel_val != '0);
  assign tick   = (presc == PS_MAX);

  always_comb begin
    state_n = state;
    presc_n = presc;
    num_n   = num;
    case (state)
      STANDBY: begin
        num_n = sel_val;
        if (iniciar && !pausar && !cancelar && sel_ok) begin
          state_n = CONTANDO;
          presc_n = '0;
        end
      end
      CONTANDO: begin
        if (cancelar) begin
          state_n = STANDBY;
        end else if (pausar) begin
          state_n = PAUSA;
        end else if (tick) begin
          presc_n = '0;
          num_n   = num - WIDTH'(1);
          if (num == WIDTH'(1))
            state_n = FIN;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      PAUSA: begin
        if (cancelar)
          state_n = STANDBY;
        else if (iniciar && !pausar)
          state_n = CONTANDO;
      end
      FIN: begin
        num_n = '0;
        if (cancelar || iniciar)
          state_n = STANDBY;
      end
      default: begin
        state_n = STANDBY;
        num_n   = '0;
        presc_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STANDBY;
      presc     <= '0;
      num       <= '0;
      activo    <= 1'b0;
      pausado   <= 1'b0;
      fin       <= 1'b0;
      alarma    <= 1'b0;
      error_sel <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      num       <= num_n;
      activo    <= (state_n == CONTANDO);
      pausado   <= (state_n == PAUSA);
      fin       <= (state_n == FIN) && (state != FIN);
      alarma    <= (state_n == FIN);
      error_sel <= (state_n == STANDBY) && sel_multi;
    end
  end

endmodule

// File: tb/tb_temporizador_programable.sv
// Bench for temporizador_programable: directed scenarios plus random
// stimulus against an elapsed-time reference model.
module tb_temporizador_programable;

  localparam int W    = 5;
  localparam int NP   = 4;
  localparam int TICK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP:0]   seleccion = '0;
  logic [W-1:0]  T_selec = '0;
  logic          iniciar = 1'b0;
  logic          pausar = 1'b0;
  logic          cancelar = 1'b0;
  logic [W-1:0]  num;
  logic          activo, pausado, fin, alarma, error_sel;
  logic [W+4:0]  dut_vec;

  int errors = 0;
  int checks = 0;
  int presets [NP] = '{15, 5, 10, 20};

  typedef enum int {M_SB, M_RUN, M_PA, M_FIN} mode_t;
  mode_t        m_mode = M_SB;
  int           m_total = 0;
  int           m_elapsed = 0;
  logic [W-1:0] m_num = '0;
  logic         m_fin = 1'b0;
  logic         m_err = 1'b0;

  temporizador_programable #(
    .WIDTH(W),
    .N_PRESETS(NP),
    .PRESETS({5'd20, 5'd10, 5'd5, 5'd15}),
    .TICK_DIV(TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seleccion(seleccion),
    .T_selec(T_selec),
    .iniciar(iniciar),
    .pausar(pausar),
    .cancelar(cancelar),
    .num(num),
    .activo(activo),
    .pausado(pausado),
    .fin(fin),
    .alarma(alarma),
    .error_sel(error_sel)
  );

  always #5 clk = ~clk;

  assign dut_vec = {num, activo, pausado, fin, alarma, error_sel};

  function automatic int sel_value();
    int n = $countones(seleccion);
    if (n != 1) return 0;
    for (int i = 0; i < NP; i++)
      if (seleccion[i]) return presets[i];
    return int'(T_selec);
  endfunction

  function automatic logic [W+4:0] exp_vec();
    return {m_num, m_mode == M_RUN, m_mode == M_PA,
            m_fin, m_mode == M_FIN, m_err};
  endfunction

  // Remaining time = programmed seconds minus whole seconds of run time.
  task automatic model_update();
    int sv = sel_value();
    m_fin = 1'b0;
    case (m_mode)
      M_SB: begin
        m_num = W'(sv);
        if (iniciar && !pausar && !cancelar && sv != 0) begin
          m_mode = M_RUN;
          m_total = sv;
          m_elapsed = 0;
        end
      end
      M_RUN: begin
        if (cancelar) m_mode = M_SB;
        else if (pausar) m_mode = M_PA;
        else begin
          m_elapsed++;
          m_num = W'(m_total - m_elapsed / TICK);
          if (m_elapsed == m_total * TICK) begin
            m_mode = M_FIN;
            m_fin = 1'b1;
          end
        end
      end
      M_PA: begin
        if (cancelar) m_mode = M_SB;
        else if (iniciar && !pausar) m_mode = M_RUN;
      end
      M_FIN: begin
        if (cancelar || iniciar) m_mode = M_SB;
      end
      default: m_mode = M_SB;
    endcase
    m_err = (m_mode == M_SB) && ($countones(seleccion) > 1);
  endtask

  task automatic model_reset();
    m_mode = M_SB;
    m_num = '0;
    m_fin = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic step(input logic ini, input logic pau, input logic can);
    iniciar = ini;
    pausar = pau;
    cancelar = can;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", dut_vec, 10'b0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", dut_vec, 10'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_countdown();
    int fins = 0;
    int k = 0;
    seleccion = 5'b00010;
    T_selec = '0;
    step(0, 0, 0);
    checks++;
    if (num !== 5'd5) begin
      errors++;
      $display("FAIL cd_load: num=%0d expected 5", num);
    end
    step(1, 0, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL cd_start: got %b expected %b", dut_vec, exp_vec());
    end
    while (!alarma && k < 40) begin
      step(0, 0, 0);
      k++;
      if (fin) fins++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL cd_step%0d: got %b expected %b",
                 k, dut_vec, exp_vec());
      end
    end
    checks++;
    if (k != 20) begin
      errors++;
      $display("FAIL cd_length: cycles=%0d expected 20", k);
    end
    repeat (3) begin
      step(0, 0, 0);
      if (fin) fins++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL cd_hold: got %b expected %b", dut_vec, exp_vec());
      end
    end
    checks++;
    if (fins != 1) begin
      errors++;
      $display("FAIL cd_fin_pulses: count=%0d expected 1", fins);
    end
    step(0, 0, 1);
    step(0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec() || num !== 5'd5) begin
      errors++;
      $display("FAIL cd_ack: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pause();
    int counted = 0;
    int n = 0;
    seleccion = 5'b10000;
    T_selec = 5'd3;
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) begin
      if (activo) counted++;
      step(0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pa_run: got %b expected %b", dut_vec, exp_vec());
      end
    end
    repeat (20) begin
      step(0, 1, 0);
      checks++;
      if (num !== 5'd2 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pa_frozen: got %b expected %b num 2",
                 dut_vec, exp_vec());
      end
    end
    step(1, 0, 0);
    while (!alarma && n < 50) begin
      if (activo) counted++;
      step(0, 0, 0);
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pa_resume: got %b expected %b", dut_vec, exp_vec());
      end
    end
    checks++;
    if (counted != 12) begin
      errors++;
      $display("FAIL pa_total: counted=%0d expected 12", counted);
    end
    step(0, 0, 1);
  endtask

  task automatic test_error_sel();
    seleccion = 5'b01100;
    step(0, 0, 0);
    checks++;
    if (error_sel !== 1'b1 || num !== '0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL err_flag: got %b expected %b", dut_vec, exp_vec());
    end
    step(1, 0, 0);
    checks++;
    if (activo !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL err_start: got %b expected %b", dut_vec, exp_vec());
    end
    seleccion = 5'b00000;
    step(0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL err_clear: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_priority();
    seleccion = 5'b00001;
    step(0, 0, 0);
    step(1, 0, 0);
    repeat ($urandom_range(3, 10)) step(0, 0, 0);
    step(1, 1, 1);
    checks++;
    if (activo !== 1'b0 || pausado !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL pri_cancel: got %b expected %b", dut_vec, exp_vec());
    end
    step(0, 0, 0);
    checks++;
    if (num !== W'(presets[0]) || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL pri_reload: num=%0d expected %0d", num, presets[0]);
    end
  endtask

  task automatic test_sel_change();
    int n = 0;
    seleccion = 5'b00100;
    step(0, 0, 0);
    step(1, 0, 0);
    while (!alarma && n < 100) begin
      seleccion = 5'($urandom);
      T_selec = 5'($urandom);
      step(0, 0, 0);
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL sc_step: got %b expected %b", dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != 40) begin
      errors++;
      $display("FAIL sc_length: cycles=%0d expected 40", n);
    end
    seleccion = 5'b10000;
    T_selec = '0;
    step(0, 0, 1);
    step(1, 0, 0);
    checks++;
    if (activo !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL sc_zero_manual: got %b expected %b",
               dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    seleccion = 5'b00001;
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (num !== '0 || activo !== 1'b0 || alarma !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: num=%0d activo=%b expected 0 0",
               num, activo);
    end
    rst = 1'b0;
    model_reset();
    step(0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_reload: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic ini, pau, can;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: seleccion = '0;
          1: seleccion = 5'($urandom);
          default: seleccion = 5'(1 << $urandom_range(0, NP));
        endcase
        T_selec = 5'($urandom_range(0, 6));
      end
      ini = ($urandom_range(0, 99) < 30);
      pau = ($urandom_range(0, 99) < 10);
      can = ($urandom_range(0, 99) < 4);
      step(ini, pau, can);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rnd_%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_error_sel();
    test_priority();
    test_sel_change();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
